// File: rtl/fp_add_core_if.sv
// Operand/result bundle for the binary64 add/subtract core.
// master drives operands and observes the result; slave is the core.
interface fp_add_core_if;
   logic        in_valid;
   logic        sa;
   logic        sb;
   logic [10:0] ea;
   logic [10:0] eb;
   logic [52:0] fa;
   logic [52:0] fb;
   logic [3:0]  fla;
   logic [3:0]  flb;
   logic [52:0] nan;
   logic        sub;
   logic [1:0]  RM;
   logic        out_valid;
   logic        ss;
   logic [10:0] es;
   logic [56:0] fs;
   logic [57:0] fls;

   modport master (
      output in_valid, sa, sb, ea, eb, fa, fb, fla, flb, nan, sub, RM,
      input  out_valid, ss, es, fs, fls
   );

   modport slave (
      input  in_valid, sa, sb, ea, eb, fa, fb, fla, flb, nan, sub, RM,
      output out_valid, ss, es, fs, fls
   );
endinterface

// File: rtl/fp_add_core.sv
// Binary64 add/subtract core: swap, align with sticky, add/sub, special-value
// detection. Produces an unnormalized, unrounded 2.55 sum registered once.
module fp_add_core (
   input  logic           clk,
   input  logic           rst,
   fp_add_core_if.slave   io
);

   logic         sbe;
   logic         esub;
   logic         a_big;
   logic         sl;
   logic [10:0]  el;
   logic [10:0]  ediff;
   logic [5:0]   delta;
   logic [52:0]  fl;
   logic [52:0]  fsm;
   logic [111:0] shw;
   logic [55:0]  al;
   logic [56:0]  sum;
   logic         any_nan;
   logic         any_snan;

   logic         ss_n;
   logic [10:0]  es_n;
   logic [56:0]  fs_n;
   logic [57:0]  fls_n;

   // Swap by magnitude, align the smaller operand, then add or subtract.
   always_comb begin
      sbe   = io.sb ^ io.sub;
      esub  = io.sa ^ sbe;
      a_big = (io.ea > io.eb) || ((io.ea == io.eb) && (io.fa >= io.fb));
      if (a_big) begin
         el    = io.ea;
         fl    = io.fa;
         sl    = io.sa;
         fsm   = io.fb;
         ediff = io.ea - io.eb;
      end else begin
         el    = io.eb;
         fl    = io.fb;
         sl    = sbe;
         fsm   = io.fa;
         ediff = io.eb - io.ea;
      end
      delta = (ediff > 11'd56) ? 6'd56 : ediff[5:0];
      // Upper 56 bits land on fs[55:0]; everything at or below fs[0] folds into sticky.
      shw = {fsm, 3'b000, 56'd0} >> delta;
      al  = {shw[111:57], shw[56] | (|shw[55:0])};
      if (esub) begin
         sum = {1'b0, fl, 3'b000} - {1'b0, al};
      end else begin
         sum = {1'b0, fl, 3'b000} + {1'b0, al};
      end
   end

   // Resolve NaN / infinity / exact-zero cases into the next output values.
   always_comb begin
      any_nan  = io.fla[1] | io.fla[0] | io.flb[1] | io.flb[0];
      any_snan = io.fla[0] | io.flb[0];
      ss_n     = sl;
      es_n     = el;
      fs_n     = sum;
      fls_n    = '0;
      if (any_nan) begin
         ss_n  = 1'b0;
         es_n  = 11'h7FF;
         fs_n  = '0;
         fls_n = {2'b00, 1'b1, any_snan, 1'b1, io.nan};
      end else if (io.fla[2] && io.flb[2] && esub) begin
         ss_n  = 1'b0;
         es_n  = 11'h7FF;
         fs_n  = '0;
         fls_n = {2'b00, 3'b111, 53'h08000000000000};
      end else if (io.fla[2] || io.flb[2]) begin
         ss_n  = io.fla[2] ? io.sa : sbe;
         es_n  = 11'h7FF;
         fs_n  = '0;
         fls_n = {1'b0, 1'b1, 2'b00, 1'b1, 53'd0};
      end else if ((sum == '0) || (io.fla[3] && io.flb[3])) begin
         ss_n  = esub ? (io.RM == 2'b11) : io.sa;
         fs_n  = '0;
         fls_n = {1'b1, 57'd0};
      end
   end

   // Single output register stage; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         io.out_valid <= 1'b0;
         io.ss        <= 1'b0;
         io.es        <= '0;
         io.fs        <= '0;
         io.fls       <= '0;
      end else begin
         io.out_valid <= io.in_valid;
         io.ss        <= ss_n;
         io.es        <= es_n;
         io.fs        <= fs_n;
         io.fls       <= fls_n;
      end
   end

endmodule

// File: tb/tb_fp_add_core.sv
// Scoreboard bench for fp_add_core: directed cases plus randomized operands
// checked against a magnitude-level reference model.
module tb_fp_add_core;

   typedef struct {
      logic        sa, sb;
      logic [10:0] ea, eb;
      logic [52:0] fa, fb;
      logic [3:0]  fla, flb;
      logic [52:0] nan;
      logic        sub;
      logic [1:0]  rm;
   } op_t;

   typedef struct {
      logic        ss;
      logic [10:0] es;
      logic [56:0] fs;
      logic [57:0] fls;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   exp_t exp_q[$];
   exp_t mon_e;

   fp_add_core_if bus ();

   fp_add_core dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference: compare magnitudes as {exponent,significand} keys, align with
   // plain integer shifts and masks, add/subtract as 64-bit integers.
   function automatic exp_t model(input op_t o);
      exp_t r;
      bit sbe, esub, a_big, sl, sticky;
      longint unsigned ka, kb, fl, fsx, mask, res;
      logic [10:0] el, esm;
      int d;
      r.ss = 1'b0; r.es = '0; r.fs = '0; r.fls = '0;
      sbe  = o.sb ^ o.sub;
      esub = o.sa ^ sbe;
      if (o.fla[1] | o.fla[0] | o.flb[1] | o.flb[0]) begin
         r.es  = 11'h7FF;
         r.fls = {2'b00, 1'b1, (o.fla[0] | o.flb[0]), 1'b1, o.nan};
         return r;
      end
      if (o.fla[2] && o.flb[2] && esub) begin
         r.es  = 11'h7FF;
         r.fls = {2'b00, 3'b111, 53'h08000000000000};
         return r;
      end
      if (o.fla[2] || o.flb[2]) begin
         r.ss  = o.fla[2] ? o.sa : sbe;
         r.es  = 11'h7FF;
         r.fls = {1'b0, 1'b1, 2'b00, 1'b1, 53'd0};
         return r;
      end
      ka = {o.ea, o.fa};
      kb = {o.eb, o.fb};
      a_big = (ka >= kb);
      el  = a_big ? o.ea : o.eb;
      esm = a_big ? o.eb : o.ea;
      fl  = a_big ? o.fa : o.fb;
      fsx = a_big ? o.fb : o.fa;
      sl  = a_big ? o.sa : sbe;
      d = int'(el) - int'(esm);
      if (d > 56) d = 56;
      fsx    = fsx * 8;
      mask   = (64'd1 << d) - 64'd1;
      sticky = ((fsx & mask) != 0);
      fsx    = (fsx >> d) | longint'(sticky);
      res    = esub ? (fl * 8 - fsx) : (fl * 8 + fsx);
      r.es = el;
      if (res == 0) begin
         r.ss  = esub ? (o.rm == 2'b11) : o.sa;
         r.fls = {1'b1, 57'd0};
      end else begin
         r.ss = sl;
         r.fs = res[56:0];
      end
      return r;
   endfunction

   task automatic drive(input op_t o, input bit v);
      bus.in_valid = v;
      bus.sa = o.sa;   bus.sb = o.sb;
      bus.ea = o.ea;   bus.eb = o.eb;
      bus.fa = o.fa;   bus.fb = o.fb;
      bus.fla = o.fla; bus.flb = o.flb;
      bus.nan = o.nan; bus.sub = o.sub; bus.RM = o.rm;
   endtask

   // Issue one operation with an explicit expected result.
   task automatic send_exp(input op_t o, input exp_t e);
      drive(o, 1'b1);
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic send_rand(input op_t o, input bit v);
      drive(o, v);
      if (v) exp_q.push_back(model(o));
      @(posedge clk); #1;
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
      check({tag, "_ss"}, {63'd0, bus.ss}, 64'd0);
      check({tag, "_es"}, {53'd0, bus.es}, 64'd0);
      check({tag, "_fs"}, {7'd0, bus.fs}, 64'd0);
      check({tag, "_fls"}, {6'd0, bus.fls}, 64'd0);
   endtask

   function automatic op_t blank();
      op_t o;
      o.sa = 0; o.sb = 0; o.ea = 0; o.eb = 0; o.fa = 0; o.fb = 0;
      o.fla = 0; o.flb = 0; o.nan = 0; o.sub = 0; o.rm = 0;
      return o;
   endfunction

   function automatic exp_t mk(input logic s, input logic [10:0] e, input logic [56:0] f, input logic [57:0] fl);
      exp_t r;
      r.ss = s; r.es = e; r.fs = f; r.fls = fl;
      return r;
   endfunction

   function automatic void rand_operand(output logic [10:0] e, output logic [52:0] f, output logic [3:0] fl);
      int unsigned c;
      logic [63:0] rw;
      c  = $urandom_range(0, 99);
      rw = {$urandom, $urandom};
      fl = 4'b0000;
      if (c < 4) begin
         e = 0; f = 0; fl = 4'b1000;
      end else if (c < 8) begin
         e = 11'h7FF; f = rw[52:0]; fl = 4'b0100;
      end else if (c < 11) begin
         e = 11'h7FF; f = rw[52:0]; fl = 4'b0010;
      end else if (c < 13) begin
         e = 11'h7FF; f = rw[52:0]; fl = 4'b0011;
      end else if (c < 20) begin
         e = 11'd1; f = {1'b0, rw[51:0]};
      end else begin
         e = 11'($urandom_range(1, 2046)); f = {1'b1, rw[51:0]};
      end
   endfunction

   function automatic op_t rand_op();
      op_t o;
      int unsigned c;
      int ne;
      logic [63:0] rw;
      o = blank();
      rand_operand(o.ea, o.fa, o.fla);
      rand_operand(o.eb, o.fb, o.flb);
      c = $urandom_range(0, 99);
      if (c < 10 && o.fla == 4'b0000) begin
         o.eb = o.ea; o.fb = o.fa; o.flb = 4'b0000;
      end else if (c < 45 && o.fla == 4'b0000 && o.flb == 4'b0000 && o.ea > 1) begin
         ne = int'(o.ea) + int'($urandom_range(0, 6)) - 3;
         if (ne < 1) ne = 1;
         if (ne > 2046) ne = 2046;
         o.eb = 11'(ne);
         rw = {$urandom, $urandom};
         o.fb = {1'b1, rw[51:0]};
      end
      rw = {$urandom, $urandom};
      o.nan = {1'b1, rw[51:0]};
      o.sa  = 1'($urandom_range(0, 1));
      o.sb  = 1'($urandom_range(0, 1));
      o.sub = 1'($urandom_range(0, 1));
      o.rm  = 2'($urandom_range(0, 3));
      return o;
   endfunction

   // Monitor: pop and compare whenever the core presents a valid result.
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got out_valid=1 expected no pending result");
         end else begin
            mon_e = exp_q.pop_front();
            check("ss", {63'd0, bus.ss}, {63'd0, mon_e.ss});
            check("es", {53'd0, bus.es}, {53'd0, mon_e.es});
            check("fs", {7'd0, bus.fs}, {7'd0, mon_e.fs});
            check("fls", {6'd0, bus.fls}, {6'd0, mon_e.fls});
         end
      end
   end

   initial begin
      op_t o;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      drive(blank(), 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;

      // 3.0 + 3.0
      o = blank(); o.fa = 53'h18000000000000; o.fb = 53'h18000000000000;
      o.ea = 11'h400; o.eb = 11'h400;
      send_exp(o, mk(1'b0, 11'h400, 57'h180000000000000, '0));
      // 2.0 - 1.0
      o = blank(); o.fa = 53'h10000000000000; o.fb = 53'h10000000000000;
      o.ea = 11'h400; o.eb = 11'h3FF; o.sub = 1;
      send_exp(o, mk(1'b0, 11'h400, 57'h040000000000000, '0));
      // 3.0 - 3.0, RNE then RD
      o = blank(); o.fa = 53'h18000000000000; o.fb = 53'h18000000000000;
      o.ea = 11'h400; o.eb = 11'h400; o.sub = 1;
      send_exp(o, mk(1'b0, 11'h400, '0, {1'b1, 57'd0}));
      o.rm = 2'b11;
      send_exp(o, mk(1'b1, 11'h400, '0, {1'b1, 57'd0}));
      // 1.0 + 2^-60: sticky only
      o = blank(); o.fa = 53'h10000000000000; o.fb = 53'h10000000000000;
      o.ea = 11'h3FF; o.eb = 11'h3C3;
      send_exp(o, mk(1'b0, 11'h3FF, 57'h080000000000001, '0));
      // 1.0 + tiny, shift far beyond saturation
      o.eb = 11'h001;
      send_exp(o, mk(1'b0, 11'h3FF, 57'h080000000000001, '0));
      // +inf - +inf
      o = blank(); o.fla = 4'b0100; o.flb = 4'b0100; o.ea = 11'h7FF; o.eb = 11'h7FF;
      o.fa = 53'h10000000000000; o.fb = 53'h10000000000000; o.sub = 1;
      send_exp(o, mk(1'b0, 11'h7FF, '0, {2'b00, 3'b111, 53'h08000000000000}));
      // 1.0 - (+inf) gives -inf
      o = blank(); o.flb = 4'b0100; o.eb = 11'h7FF; o.fb = 53'h10000000000000;
      o.ea = 11'h3FF; o.fa = 53'h10000000000000; o.sub = 1;
      send_exp(o, mk(1'b1, 11'h7FF, '0, {1'b0, 1'b1, 2'b00, 1'b1, 53'd0}));
      // +0 + (-2.0) returns the other operand
      o = blank(); o.fla = 4'b1000; o.sb = 1; o.eb = 11'h400; o.fb = 53'h10000000000000;
      send_exp(o, mk(1'b1, 11'h400, 57'h080000000000000, '0));
      // +0 + (-0): effective subtraction, RNE then RD
      o = blank(); o.fla = 4'b1000; o.flb = 4'b1000; o.sb = 1;
      send_exp(o, mk(1'b0, 11'h000, '0, {1'b1, 57'd0}));
      o.rm = 2'b11;
      send_exp(o, mk(1'b1, 11'h000, '0, {1'b1, 57'd0}));

      // Randomized operands with occasional idle cycles
      for (int i = 0; i < 600; i++) begin
         send_rand(rand_op(), ($urandom_range(0, 99) >= 15));
      end

      // SNaN + 1.0, then reset together with a new operand
      o = blank(); o.fla = 4'b0011; o.ea = 11'h7FF; o.fa = 53'h14000000000000;
      o.eb = 11'h3FF; o.fb = 53'h10000000000000; o.nan = 53'h0C000000000000;
      send_exp(o, mk(1'b0, 11'h7FF, '0, {2'b00, 3'b111, 53'h0C000000000000}));
      o = blank(); o.ea = 11'h400; o.eb = 11'h400;
      o.fa = 53'h18000000000000; o.fb = 53'h18000000000000;
      drive(o, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_zero("rst_mid");
      rst = 1'b0;
      drive(blank(), 1'b0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      @(posedge clk); #1;
      check("drain", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_add_core.md
# fp_add_core

Double-precision floating-point add/subtract core of the FPU datapath. It sits between the operand unpacker and the normalize/round stage. It takes unpacked significands, biased exponents, signs and special-value flags for two operands. It produces an aligned, unnormalized, unrounded sum plus special-case flags, with the result registered once.

## Interface
- No parameters; the format is fixed to IEEE-754 binary64.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operands valid this cycle.
- `sa`, `sb` input 1: operand signs.
- `ea`, `eb` input 11: biased exponents. Denormals arrive with exponent 1. Zero arrives with exponent 0.
- `fa`, `fb` input 53: significands in 1.52 format, leading bit explicit (bit 52). Denormals have bit 52 = 0.
- `fla`, `flb` input 4: operand flags: [3] ZERO, [2] INF, [1] NAN, [0] SNAN.
- `nan` input 53: NaN significand preselected by the unpacker.
- `sub` input 1: 1 = compute a−b, 0 = a+b.
- `RM` input 2: rounding mode: 00 RNE, 01 RZ, 10 RU (+∞), 11 RD (−∞).
- `out_valid` output 1: registered `in_valid`.
- `ss` output 1: result sign.
- `es` output 11: result biased exponent.
- `fs` output 57: result significand in 2.55 format. [56:55] are integer bits. [54:3] hold the 52 fraction bits. [2] is guard, [1] is round, [0] is sticky.
- `fls` output 58: [57] ZEROs, [56] INFs, [55] NANs, [54] INV, [53] SPEC (special path taken), [52:0] NaN significand.

## Operation
- Effective operand b: sign `sb' = sb ^ sub`. Effective subtraction: `esub = sa ^ sb'`.
- Swap: the larger operand is chosen by the larger exponent. On equal exponents, compare significands. The larger operand is L (eL, fL, sL) and the other is S.
- Alignment: `delta = eL − eS`, saturated at 56. fS is shifted right by delta into a 55-bit fraction field. All bits shifted past fs[1] are ORed into the sticky bit fs[0].
- Add (`esub=0`): `fs = fL + fS_aligned`, with a carry into fs[56]. `ss = sL`.
- Subtract (`esub=1`): `fs = fL − fS_aligned` in 57-bit arithmetic, with sticky carried as the LSB. The result is non-negative by construction. `ss = sL`.
- `es = eL` always; there is no normalization here. Leading zeros in fs and carry into fs[56] are resolved downstream.
- Exact zero result, from a non-special path or from both operands zero:
  - Sign rule: if `esub=0`, `ss = sa`. If `esub=1`, `ss = (RM==11)`.
  - ZEROs=1 and fs=0. es is that of L.
- Special path (SPEC=1) when any operand is NAN or INF:
  - NaN: NANs=1, fls[52:0]=`nan`. INV=1 if either SNAN.
  - ∞ − ∞ (both INF, esub=1): INV=1, NANs=1, fls[52:0] = quiet default NaN (bit 51 set, others 0).
  - One or both INF, otherwise: INFs=1. `ss` is the infinite operand's effective sign.
  - On the special path, fs=0 and es=11'h7FF.
- A zero operand with a nonzero other operand needs no special handling. The normal path returns the other operand with its effective sign.
- When no special case applies, fls[57:53]=0 and fls[52:0]=0.

## Timing
- Combinational datapath followed by one output register stage. Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one operation per cycle. There is no back-pressure.
- Outputs update every cycle regardless of `in_valid`. `out_valid` qualifies them.
- Reset: `out_valid`, `ss`, `es`, `fs` and `fls` all clear to 0 on the first edge with `rst=1`.
- Reset mid-operation discards the in-flight result.
- Reset has priority over a simultaneous `in_valid`.

## Test plan
- 3.0+3.0: fa=fb=53'h18000000000000, ea=eb=11'h400, sub=0, RM=00. After 1 cycle: ss=0, es=11'h400, fs=57'h180000000000000, fls=0.
- 2.0−1.0: fa=fb=53'h10000000000000, ea=11'h400, eb=11'h3FF, sub=1. Expect: ss=0, es=11'h400, fs=57'h040000000000000.
- 3.0−3.0 with sub=1: RM=00 gives ss=0, ZEROs=1, fs=0. RM=11 gives ss=1, ZEROs=1.
- 1.0 + 2^-60: fa=fb=53'h10000000000000, ea=11'h3FF, eb=11'h3C3. Expect: es=11'h3FF, fs=57'h080000000000001 (sticky only).
- +∞ − +∞: fla=flb=4'b0100, sub=1. Expect: INV=1, NANs=1, SPEC=1, fls[52:0]=53'h08000000000000.
- SNaN + 1.0: fla=4'b0011, nan=53'h0C000000000000. Expect: NANs=1, INV=1, fls[52:0]=`nan`. Then assert rst together with a new operand: all outputs are 0 on the next cycle.
